// File: rtl/piso_pkg.sv
// Shared types and reset constants for the piso_tx serial transmitter.
package piso_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;

   localparam logic RST_RDY = 1'b1;
   localparam logic RST_SD  = 1'b0;
   localparam logic RST_FRM = 1'b0;

endpackage

// File: rtl/bit_cnt.sv
// Loadable down-counter with decrement enable and a zero flag; it never wraps below zero.
module bit_cnt #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   assign zero = (cnt == '0);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && !zero) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter, MSB first, valid/ready load handshake.
// Define PISO_TX_PARITY_EN to append an even-parity bit after the LSB.
module piso_tx
   import piso_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] d,
   input  logic         vld,
   input  logic         en,
   output logic         rdy,
   output logic         sd,
   output logic         frm,
   output logic         done
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

   state_t       state;
   // The current MSB lives in sd itself; tail holds the bits still to come.
   logic [N-2:0] tail;
   logic         load;
   logic         last;
`ifdef PISO_TX_PARITY_EN
   logic         par;
`endif

   assign load = (state == IDLE) && vld && rdy;

   bit_cnt #(
      .W (CW)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (LAST_IDX),
      .dec      ((state == SHIFT) && en),
      .zero     (last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         tail  <= '0;
         rdy   <= RST_RDY;
         sd    <= RST_SD;
         frm   <= RST_FRM;
         done  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  state <= SHIFT;
                  tail  <= d[N-2:0];
                  sd    <= d[N-1];
                  frm   <= 1'b1;
                  rdy   <= 1'b0;
`ifdef PISO_TX_PARITY_EN
                  par   <= ^d;
`endif
               end
            end

            SHIFT: begin
               if (en) begin
                  if (last) begin
`ifdef PISO_TX_PARITY_EN
                     state <= PARITY;
                     sd    <= par;
`else
                     state <= IDLE;
                     sd    <= 1'b0;
                     frm   <= 1'b0;
                     rdy   <= 1'b1;
                     done  <= 1'b1;
`endif
                  end else begin
                     sd   <= tail[N-2];
                     tail <= tail << 1;
                  end
               end
            end

`ifdef PISO_TX_PARITY_EN
            PARITY: begin
               if (en) begin
                  state <= IDLE;
                  sd    <= 1'b0;
                  frm   <= 1'b0;
                  rdy   <= 1'b1;
                  done  <= 1'b1;
               end
            end
`endif

            default: begin
               state <= IDLE;
               sd    <= 1'b0;
               frm   <= 1'b0;
               rdy   <= 1'b1;
            end
         endcase
      end
   end

endmodule
